// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the APB master/arbiter.
// FSM states, protection width and strobe/index width helpers.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam int APB_PROT_W = 3;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts one past the last grant.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  int             sh;
  int             pos;

  always_comb begin
    any   = 1'b0;
    pos   = 0;
    sh    = (int'(last) + 1) % N;
    dbl   = {req, req} >> sh;
    for (int i = 0; i < N; i++) begin
      if (!any && dbl[i]) begin
        any = 1'b1;
        pos = (i + sh) % N;
      end
    end
    grant = any ? (N'(1) << pos) : '0;
    idx   = IW'(pos);
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB4 master shared by NUM_REQ requesters with round-robin
// arbitration, wait states, error forwarding and a hung-slave timeout.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]    req_strb,
  input  logic [NUM_REQ*APB_PROT_W-1:0]  req_prot,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_W-1:0]              PADDR,
  output logic [APB_PROT_W-1:0]          PPROT,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_W-1:0]              PWDATA,
  output logic [DATA_W/8-1:0]            PSTRB,
  input  logic                           PREADY,
  input  logic [DATA_W-1:0]              PRDATA,
  input  logic                           PSLVERR
);

  localparam int SW = strb_w(DATA_W);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t state, state_n;

  logic [IW-1:0]      last;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win;
  logic               any;
  logic [CW-1:0]      cnt;
  logic               done;
  logic               abort;
  logic               accept;

  logic                  sel_write;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [SW-1:0]         sel_strb;
  logic [APB_PROT_W-1:0] sel_prot;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (win),
    .idx   (win_idx),
    .any   (any)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_strb  = req_strb[i*SW +: SW];
        sel_prot  = req_prot[i*APB_PROT_W +: APB_PROT_W];
      end
    end
  end

  // An abort is not an arbitration point; completion is.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE:  state_n = IDLE;
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    accept = PRESETn && any && (state == IDLE || done);
    if (accept) state_n = SETUP;
  end

  assign req_ready = accept ? win : '0;
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      last      <= '0;
      cnt       <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        PADDR  <= sel_addr;
        PWRITE <= sel_write;
        PWDATA <= sel_wdata;
        PSTRB  <= sel_write ? sel_strb : '0;
        PPROT  <= sel_prot;
        last   <= win_idx;
      end
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !PREADY)
        cnt <= cnt + CW'(1);
      rsp_valid <= '0;
      if (done || abort) begin
        rsp_valid <= NUM_REQ'(1) << last;
        rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
        rsp_err   <= abort | PSLVERR;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter with a transaction-level
// reference model and a response scoreboard.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR*3-1:0]   req_prot;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     PADDR;
  logic [2:0]        PPROT;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [SW-1:0]     PSTRB;
  logic              PREADY;
  logic [DW-1:0]     PRDATA;
  logic              PSLVERR;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [2:0]  pr;
  } cmd_t;

  typedef struct {
    int          r;
    logic [31:0] rd;
    bit          err;
  } rsp_t;

  cmd_t cmd[NR];
  bit   pend[NR];
  cmd_t cc;
  rsp_t rq[$];

  // Transfer model: busy, cycles since accept (k), planned wait states (w)
  bit busy;
  int k;
  int w;
  int cur;
  int last;
  bit gen_en;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_cmd(input int i);
    cmd[i].wr = 1'($urandom);
    cmd[i].ad = $urandom;
    cmd[i].wd = $urandom;
    cmd[i].st = 4'($urandom);
    cmd[i].pr = 3'($urandom);
    pend[i]   = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pend[i];
      req_write[i]           = cmd[i].wr;
      req_addr[i*AW +: AW]   = cmd[i].ad;
      req_wdata[i*DW +: DW]  = cmd[i].wd;
      req_strb[i*SW +: SW]   = cmd[i].st;
      req_prot[i*3 +: 3]     = cmd[i].pr;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 40;
    if (r == 1) return TO - 1;
    if (r < 10) return 0;
    return $urandom_range(1, 4);
  endfunction

  task automatic step();
    bit            rdy;
    bit            ab;
    bit            free;
    int            win;
    logic [NR-1:0] exp_ready;
    rsp_t          e;
    @(negedge PCLK);
    chk("PSEL", PSEL, busy);
    chk("PENABLE", PENABLE, busy && k >= 2);
    if (busy) begin
      chk("PADDR", PADDR, cc.ad);
      chk("PWRITE", PWRITE, cc.wr);
      chk("PWDATA", PWDATA, cc.wd);
      chk("PSTRB", PSTRB, cc.wr ? cc.st : 4'h0);
      chk("PPROT", PPROT, cc.pr);
    end
    rdy = busy && k >= 2 && (k - 2 == w);
    ab  = busy && k >= 2 && !rdy && (k - 1 == TO);
    if (busy && k >= 2) PREADY = rdy;
    else PREADY = 1'($urandom);
    PRDATA  = $urandom;
    PSLVERR = rdy ? ($urandom_range(0, 3) == 0) : 1'($urandom);
    free = !busy || rdy;
    for (int i = 0; i < NR; i++)
      if (!pend[i] && gen_en && $urandom_range(0, 2) != 0) new_cmd(i);
    drive();
    win = -1;
    if (free)
      for (int j = 1; j <= NR; j++) begin
        int c;
        c = (last + j) % NR;
        if (win < 0 && pend[c]) win = c;
      end
    exp_ready = (win >= 0) ? NR'(1) << win : '0;
    #1;
    chk("req_ready", req_ready, exp_ready);
    if (rdy) begin
      e.r = cur; e.rd = cc.wr ? 32'h0 : PRDATA; e.err = PSLVERR;
      rq.push_back(e);
    end
    if (ab) begin
      e.r = cur; e.rd = 32'h0; e.err = 1'b1;
      rq.push_back(e);
    end
    if (win >= 0) begin
      busy = 1'b1; k = 1; cur = win; cc = cmd[win];
      pend[win] = 1'b0; last = win; w = pick_wait();
    end else if (rdy || ab) begin
      busy = 1'b0;
    end else if (busy) begin
      k++;
    end
  endtask

  // Response scoreboard
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && rsp_valid != '0) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %b expected none", rsp_valid);
        end else begin
          e = rq.pop_front();
          chk("rsp_valid", rsp_valid, NR'(1) << e.r);
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic reset_model();
    busy = 1'b0; k = 0; w = 0; cur = 0; last = 0;
    rq.delete();
  endtask

  initial begin
    int n;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    gen_en = 1'b1;
    for (int i = 0; i < NR; i++) new_cmd(i);
    drive();
    reset_model();
    #12;
    chk("rst_PSEL", PSEL, 0);
    chk("rst_PENABLE", PENABLE, 0);
    chk("rst_PADDR", PADDR, 0);
    chk("rst_PSTRB", PSTRB, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #2 chk("first_grant", req_ready, 2'b10);
    repeat (3000) step();

    n = 0;
    while (!(busy && k >= 2) && n < 200) begin
      step();
      n++;
    end
    chk("reach_access", busy && k >= 2, 1);
    @(posedge PCLK);
    #2;
    chk("pre_reset_PENABLE", PENABLE, 1);
    for (int i = 0; i < NR; i++) if (!pend[i]) new_cmd(i);
    drive();
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_PSEL", PSEL, 0);
    chk("mid_rst_PENABLE", PENABLE, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    chk("mid_rst_rsp_hold", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    reset_model();
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #2 chk("post_reset_grant", req_ready, 2'b10);
    repeat (500) step();

    gen_en = 1'b0;
    repeat (80) step();
    chk("rsp_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
